sram_req_bridge: RTL and testbench

//  Upstream stage of the SRAM wrapper. Converts a valid/ready request stream into

---
 rtl/sram_req_bridge.sv | 168 ++++++++++++++++
 tb/tb_sram_req_bridge.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_req_bridge.sv
// Valid/ready request stream to single-port SRAM pins, with in-order responses via a
// credit-guarded response FIFO. Optional counters: define SRAM_REQ_BRIDGE_STATS_EN.
module sram_req_bridge #(
    parameter int ADDR_WIDTH = 13,
    parameter int DATA_WIDTH = 32,
    parameter int RD_LATENCY = 1,
    parameter int RSP_DEPTH  = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    // Handshake: a transfer happens on a rising edge where valid and ready are both 1;
    // a producer holds valid and payload until that edge, ready never depends on valid.
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic                    req_we_i,
    input  logic [31:0]             req_addr_i,
    input  logic [DATA_WIDTH-1:0]   req_wdata_i,
    input  logic [DATA_WIDTH/8-1:0] req_be_i,
    output logic                    rsp_valid_o,
    input  logic                    rsp_ready_i,
    output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
    output logic                    rsp_err_o,
    output logic                    sram_csb_o,
    output logic                    sram_web_o,
    output logic [DATA_WIDTH/8-1:0] sram_wmask_o,
    output logic [ADDR_WIDTH-1:0]   sram_addr_o,
    output logic [DATA_WIDTH-1:0]   sram_wdata_o,
`ifdef SRAM_REQ_BRIDGE_STATS_EN
    output logic [31:0]             stat_rd_o,
    output logic [31:0]             stat_wr_o,
    output logic [15:0]             stat_err_o,
`endif
    input  logic [DATA_WIDTH-1:0]   sram_rdata_i
);

    localparam int PIPE_N = RD_LATENCY + 1;
    localparam int PTR_W  = $clog2(RSP_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int SUM_W  = CNT_W + 1;

    logic [ADDR_WIDTH-1:0] req_word;
    logic [31:0]           addr_hi;
    logic                  req_err;
    logic                  req_fire;
    logic                  issue;

    assign req_word = req_addr_i[ADDR_WIDTH+1:2];
    assign addr_hi  = req_addr_i >> (ADDR_WIDTH + 2);
    assign req_err  = (req_addr_i[1:0] != 2'b00) || (addr_hi != 32'd0);
    assign req_fire = req_valid_i && req_ready_o;
    assign issue    = req_fire && !req_err;

    // SRAM pins are registered: a request accepted in cycle t is on the pins in t+1.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sram_csb_o   <= 1'b1;
            sram_web_o   <= 1'b1;
            sram_wmask_o <= '0;
            sram_addr_o  <= '0;
            sram_wdata_o <= '0;
        end else if (issue) begin
            sram_csb_o   <= 1'b0;
            sram_web_o   <= ~req_we_i;
            sram_wmask_o <= req_we_i ? req_be_i : '0;
            sram_addr_o  <= req_word;
            sram_wdata_o <= req_wdata_i;
        end else begin
            sram_csb_o   <= 1'b1;
            sram_web_o   <= 1'b1;
            sram_wmask_o <= '0;
        end
    end

    // Every accepted request, including errors, rides the pipe so responses stay ordered.
    logic [PIPE_N-1:0] pipe_v;
    logic [PIPE_N-1:0] pipe_we;
    logic [PIPE_N-1:0] pipe_err;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pipe_v   <= '0;
            pipe_we  <= '0;
            pipe_err <= '0;
        end else begin
            pipe_v   <= {pipe_v[PIPE_N-2:0], req_fire};
            pipe_we  <= {pipe_we[PIPE_N-2:0], req_we_i};
            pipe_err <= {pipe_err[PIPE_N-2:0], req_err};
        end
    end

    logic [CNT_W-1:0] inflight_cnt;

    always_comb begin
        inflight_cnt = '0;
        for (int i = 0; i < PIPE_N; i++) begin
            inflight_cnt = inflight_cnt + CNT_W'(pipe_v[i]);
        end
    end

    logic                  push;
    logic                  pop;
    logic [DATA_WIDTH-1:0] push_data;
    logic [DATA_WIDTH:0]   fifo_mem [RSP_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      fifo_cnt;

    assign push      = pipe_v[PIPE_N-1];
    assign push_data = (!pipe_we[PIPE_N-1] && !pipe_err[PIPE_N-1]) ? sram_rdata_i : '0;
    assign pop       = rsp_valid_o && rsp_ready_i;

    // Credits: a request is taken only if a FIFO slot is already reserved for its response.
    assign req_ready_o = rst_ni &&
        (({1'b0, inflight_cnt} + {1'b0, fifo_cnt}) < SUM_W'(RSP_DEPTH));

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {pipe_err[PIPE_N-1], push_data};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
                2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    assign rsp_valid_o = (fifo_cnt != '0);
    assign rsp_rdata_o = fifo_mem[rd_ptr][DATA_WIDTH-1:0];
    assign rsp_err_o   = fifo_mem[rd_ptr][DATA_WIDTH];

    a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(push && (fifo_cnt == CNT_W'(RSP_DEPTH))));

`ifdef SRAM_REQ_BRIDGE_STATS_EN
    // Errors are counted only as errors, never as reads or writes.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stat_rd_o  <= '0;
            stat_wr_o  <= '0;
            stat_err_o <= '0;
        end else if (req_fire) begin
            if (req_err) begin
                if (stat_err_o != '1) stat_err_o <= stat_err_o + 16'd1;
            end else if (req_we_i) begin
                if (stat_wr_o != '1) stat_wr_o <= stat_wr_o + 32'd1;
            end else begin
                if (stat_rd_o != '1) stat_rd_o <= stat_rd_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_sram_req_bridge.sv
// Bench for sram_req_bridge: SRAM macro model, directed scenarios and a randomized
// phase scored against a transaction-level memory model.
module tb_sram_req_bridge;
    localparam int AW    = 13;
    localparam int DW    = 32;
    localparam int DEPTH = 4;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          req_valid_i;
    logic          req_ready_o;
    logic          req_we_i;
    logic [31:0]   req_addr_i;
    logic [DW-1:0] req_wdata_i;
    logic [3:0]    req_be_i;
    logic          rsp_valid_o;
    logic          rsp_ready_i = 1'b0;
    logic [DW-1:0] rsp_rdata_o;
    logic          rsp_err_o;
    logic          sram_csb_o;
    logic          sram_web_o;
    logic [3:0]    sram_wmask_o;
    logic [AW-1:0] sram_addr_o;
    logic [DW-1:0] sram_wdata_o;
    logic [DW-1:0] sram_rdata_i = '0;
`ifdef SRAM_REQ_BRIDGE_STATS_EN
    logic [31:0]   stat_rd_o;
    logic [31:0]   stat_wr_o;
    logic [15:0]   stat_err_o;
`endif

    sram_req_bridge #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(1), .RSP_DEPTH(DEPTH)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
        .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .req_be_i(req_be_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
        .sram_csb_o(sram_csb_o), .sram_web_o(sram_web_o), .sram_wmask_o(sram_wmask_o),
        .sram_addr_o(sram_addr_o), .sram_wdata_o(sram_wdata_o),
`ifdef SRAM_REQ_BRIDGE_STATS_EN
        .stat_rd_o(stat_rd_o), .stat_wr_o(stat_wr_o), .stat_err_o(stat_err_o),
`endif
        .sram_rdata_i(sram_rdata_i)
    );

    // ---------------- clock / reset ----------------
    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc++;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- SRAM macro model (synchronous read, 1 cycle) ----------------
    logic [DW-1:0] smem [2**AW];
    initial for (int i = 0; i < 2**AW; i++) smem[i] = '0;

    always @(posedge clk_i) begin
        if (!sram_csb_o) begin
            if (!sram_web_o) begin
                for (int b = 0; b < 4; b++)
                    if (sram_wmask_o[b]) smem[sram_addr_o][8*b +: 8] <= sram_wdata_o[8*b +: 8];
            end else begin
                sram_rdata_i <= smem[sram_addr_o];
            end
        end
    end

    // ---------------- response-ready driver ----------------
    int rsp_mode = 0;   // 0: always ready, 1: never ready, 2: random
    always @(posedge clk_i) begin
        #1;
        case (rsp_mode)
            0:       rsp_ready_i = 1'b1;
            1:       rsp_ready_i = 1'b0;
            default: rsp_ready_i = ($urandom_range(0, 3) != 0);
        endcase
    end

    // ---------------- checking ----------------
    int vec_cnt = 0;
    int err_cnt = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model + scoreboard ----------------
    logic [DW:0]   exp_q[$];
    logic [DW-1:0] ref_mem [int];
    int            mdl_rd = 0, mdl_wr = 0, mdl_err = 0;
    int            csb_low_cnt = 0, rsp_seen = 0;
    logic [DW-1:0] last_rdata = '0;
    logic          last_err = 1'b0;
    logic          cur_issue = 1'b0;
    logic          exp_web;
    logic [3:0]    exp_wmask;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_wdata;

    function automatic logic [DW-1:0] ref_read(input int w);
        return ref_mem.exists(w) ? ref_mem[w] : '0;
    endfunction

    always @(negedge clk_i) begin
        if (!rst_ni) begin
            cur_issue = 1'b0;
            exp_q.delete();
            mdl_rd = 0; mdl_wr = 0; mdl_err = 0;
        end else begin
            // pins expected from the request accepted at the previous edge
            chk("pin_csb", sram_csb_o, !cur_issue);
            if (!sram_csb_o) csb_low_cnt++;
            if (cur_issue) begin
                chk("pin_web", sram_web_o, exp_web);
                chk("pin_wmask", sram_wmask_o, exp_wmask);
                chk("pin_addr", sram_addr_o, exp_addr);
                if (!exp_web) chk("pin_wdata", sram_wdata_o, exp_wdata);
            end
            if (rsp_valid_o) begin
                rsp_seen++;
                if (exp_q.size() == 0) begin
                    chk("rsp_unexpected", 1, 0);
                end else begin
                    chk("rsp_err", rsp_err_o, exp_q[0][DW]);
                    chk("rsp_rdata", rsp_rdata_o, exp_q[0][DW-1:0]);
                    if (rsp_ready_i) begin
                        last_rdata = rsp_rdata_o;
                        last_err   = rsp_err_o;
                        void'(exp_q.pop_front());
                    end
                end
            end
            cur_issue = 1'b0;
            if (req_valid_i && req_ready_o) begin
                int            w;
                logic          e;
                logic [DW-1:0] d;
                w = int'(req_addr_i / 4);
                e = (req_addr_i % 4 != 0) || (req_addr_i >= (32'd4 * (2**AW)));
                if (e) begin
                    exp_q.push_back({1'b1, 32'h0});
                    mdl_err++;
                end else if (req_we_i) begin
                    d = ref_read(w);
                    for (int b = 0; b < 4; b++)
                        if (req_be_i[b]) d[8*b +: 8] = req_wdata_i[8*b +: 8];
                    ref_mem[w] = d;
                    exp_q.push_back({1'b0, 32'h0});
                    mdl_wr++;
                end else begin
                    exp_q.push_back({1'b0, ref_read(w)});
                    mdl_rd++;
                end
                cur_issue = !e;
                exp_web   = !req_we_i;
                exp_wmask = req_we_i ? req_be_i : 4'h0;
                exp_addr  = AW'(w);
                exp_wdata = req_wdata_i;
            end
        end
    end

    // ---------------- driver tasks (all enter and leave at posedge+1) ----------------
    task automatic send(input logic we, input logic [31:0] addr,
                        input logic [DW-1:0] wdata, input logic [3:0] be);
        logic ok;
        int   n;
        req_valid_i = 1'b1; req_we_i = we; req_addr_i = addr;
        req_wdata_i = wdata; req_be_i = be;
        n = 0;
        do begin
            @(negedge clk_i); ok = req_ready_o;
            @(posedge clk_i); #1; n++;
        end while (!ok && n < 100);
        if (!ok) chk("send_timeout", 0, 1);
        req_valid_i = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge clk_i); n++;
        end
        if (exp_q.size() != 0) chk("drain_timeout", exp_q.size(), 0);
        @(posedge clk_i); #1;
    endtask

    task automatic rand_req();
        int            r, word;
        logic [31:0]   addr;
        r    = $urandom_range(0, 9);
        word = $urandom_range(0, 31);
        if (r == 0)      addr = word * 4 + $urandom_range(1, 3);
        else if (r == 1) addr = ($urandom | 32'h0000_8000) & ~32'h3;
        else             addr = word * 4;
        send(1'($urandom_range(0, 1)), addr, $urandom, 4'($urandom_range(0, 15)));
        if ($urandom_range(0, 3) == 0)
            repeat ($urandom_range(1, 2)) begin @(posedge clk_i); #1; end
    endtask

    // ---------------- test sequence ----------------
    int c0, acc;

    initial begin
        rst_ni = 1'b0; req_valid_i = 1'b0; req_we_i = 1'b0;
        req_addr_i = '0; req_wdata_i = '0; req_be_i = '0;
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_csb", sram_csb_o, 1);
        chk("rst_web", sram_web_o, 1);
        chk("rst_wmask", sram_wmask_o, 0);
        chk("rst_addr", sram_addr_o, 0);
        chk("rst_wdata", sram_wdata_o, 0);
        chk("rst_rsp_valid", rsp_valid_o, 0);
        chk("rst_req_ready", req_ready_o, 0);
        rst_ni = 1'b1;
        @(negedge clk_i);
        chk("ready_after_rst", req_ready_o, 1);
        @(posedge clk_i); #1;

        // word write then read back, with read latency measured
        c0 = csb_low_cnt;
        send(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF);
        wait_drain();
        chk("t1_wr_csb_cycles", csb_low_cnt - c0, 1);
        chk("t1_wr_rdata", last_rdata, 0);
        send(1'b0, 32'h10, '0, 4'h0);
        @(negedge clk_i); chk("t1_lat_c1", rsp_valid_o, 0);
        @(negedge clk_i); chk("t1_lat_c2", rsp_valid_o, 0);
        @(negedge clk_i); chk("t1_lat_c3", rsp_valid_o, 1);
        @(posedge clk_i); #1;
        wait_drain();
        chk("t1_rd_rdata", last_rdata, 32'hDEAD_BEEF);

        // byte-enable merge
        send(1'b1, 32'h20, 32'h1122_3344, 4'hF);
        send(1'b1, 32'h20, 32'h0000_AB00, 4'h2);
        send(1'b0, 32'h20, '0, 4'h0);
        wait_drain();
        chk("t2_merge", last_rdata, 32'h1122_AB44);

        // misaligned and out-of-range never reach the SRAM
        c0 = csb_low_cnt;
        send(1'b0, 32'h2, '0, 4'h0);
        send(1'b1, 32'h8000, 32'hFFFF_FFFF, 4'hF);
        wait_drain();
        chk("t3_csb_untouched", csb_low_cnt - c0, 0);
        chk("t3_err", last_err, 1);

        // backpressure: credits stop at DEPTH, then drain one per cycle
        @(negedge clk_i); rsp_mode = 1;
        @(posedge clk_i); #1;
        acc = 0; req_valid_i = 1'b1; req_we_i = 1'b0;
        for (int i = 0; i < 10; i++) begin
            req_addr_i = 32'($urandom_range(0, 31) * 4);
            @(negedge clk_i); if (req_ready_o) acc++;
            @(posedge clk_i); #1;
        end
        req_valid_i = 1'b0;
        chk("t4_accepts", acc, DEPTH);
        @(negedge clk_i);
        chk("t4_ready_low", req_ready_o, 0);
        chk("t4_full_valid", rsp_valid_o, 1);
        rsp_mode = 0;
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk_i); chk("t4_stream", rsp_valid_o && rsp_ready_i, 1);
        end
        @(negedge clk_i); chk("t4_empty", rsp_valid_o, 0);
        @(posedge clk_i); #1;

        // sustained one request per cycle
        c0 = cyc;
        for (int i = 0; i < 16; i++) send(1'b0, 32'(i * 4), '0, 4'h0);
        chk("b2b_cycles", cyc - c0, 16);
        wait_drain();

        // reset with reads in flight
        send(1'b0, 32'h10, '0, 4'h0);
        send(1'b0, 32'h14, '0, 4'h0);
        send(1'b0, 32'h18, '0, 4'h0);
        chk("t5_pre_csb", sram_csb_o, 0);
        rst_ni = 1'b0;
        #1;
        chk("t5_csb", sram_csb_o, 1);
        chk("t5_rsp_valid", rsp_valid_o, 0);
        chk("t5_req_ready", req_ready_o, 0);
        repeat (3) @(posedge clk_i);
        #1; rst_ni = 1'b1;
        c0 = rsp_seen;
        repeat (10) @(posedge clk_i);
        #1;
        chk("t5_no_stale", rsp_seen - c0, 0);

        // mixed traffic for the counters
        for (int i = 0; i < 5; i++) send(1'b0, 32'(i * 4), '0, 4'h0);
        for (int i = 0; i < 3; i++) send(1'b1, 32'h100 + 32'(i * 4), $urandom, 4'hF);
        send(1'b0, 32'h1, '0, 4'h0);
        send(1'b1, 32'h1_0000, '0, 4'hF);
        wait_drain();
`ifdef SRAM_REQ_BRIDGE_STATS_EN
        chk("t6_stat_rd", stat_rd_o, 5);
        chk("t6_stat_wr", stat_wr_o, 3);
        chk("t6_stat_err", stat_err_o, 2);
`endif

        // randomized traffic with random response backpressure
        rsp_mode = 2;
        for (int i = 0; i < 400; i++) rand_req();
        @(negedge clk_i); rsp_mode = 0;
        @(posedge clk_i); #1;
        wait_drain();
        chk("final_queue_empty", exp_q.size(), 0);
        chk("final_rsp_idle", rsp_valid_o, 0);
`ifdef SRAM_REQ_BRIDGE_STATS_EN
        chk("final_stat_rd", stat_rd_o, mdl_rd);
        chk("final_stat_wr", stat_wr_o, mdl_wr);
        chk("final_stat_err", stat_err_o, mdl_err);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
